// File: rtl/lc3_memaccess_fsm.sv
// LC3 memory-access stage: runs LD/LDR/LDI/ST/STR/STI data-memory accesses
// over a req/ack handshake, including the pointer read of LDI/STI, with a
// bounded wait per request and a one-cycle completion pulse.
module lc3_memaccess_fsm #(
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_valid_in,
    input  logic [15:0]       IR_Exec,
    input  logic [DATA_W-1:0] aluout,
    input  logic [DATA_W-1:0] M_Data,
    input  logic              Mem_Control_out,
    output logic              mem_busy,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_din,
    input  logic [DATA_W-1:0] dmem_dout,
    input  logic              dmem_ack,
    output logic [DATA_W-1:0] memout,
    output logic              mem_done,
    output logic              mem_err
);

    // Wide enough to hold TIMEOUT_CYCLES itself.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PTR  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_reg;
    logic                is_store_reg;
    logic [DATA_W-1:0]   store_data_reg;
    logic [CNT_W-1:0]    wait_cnt_reg;
    logic [CNT_W-1:0]    wait_cnt_next;
    logic                timeout_hit;
    logic [3:0]          opcode;
    logic                is_mem_op;
    logic                is_store_op;
    logic [11:0]         unused_ir_bits;

    assign opcode         = IR_Exec[15:12];
    assign unused_ir_bits = IR_Exec[11:0];

    // The pipe stalls for the whole access, including the completion cycle.
    assign mem_busy = (state_reg != IDLE);

    // Wait count including the current un-acked cycle; abort when it reaches the limit.
    assign wait_cnt_next = wait_cnt_reg + CNT_W'(1);
    assign timeout_hit   = (wait_cnt_next == CNT_W'(TIMEOUT_CYCLES));

    // Opcode decode: LD/LDR/LDI are loads, ST/STR/STI are stores.
    always_comb begin
        is_mem_op   = 1'b0;
        is_store_op = 1'b0;
        case (opcode)
            4'b0010, 4'b0110, 4'b1010: is_mem_op = 1'b1;
            4'b0011, 4'b0111, 4'b1011: begin
                is_mem_op   = 1'b1;
                is_store_op = 1'b1;
            end
            default: ;
        endcase
    end

    // Access sequencer with registered handshake and result outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_din       <= '0;
            memout         <= '0;
            mem_done       <= 1'b0;
            mem_err        <= 1'b0;
            wait_cnt_reg   <= '0;
            is_store_reg   <= 1'b0;
            store_data_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (mem_valid_in && is_mem_op) begin
                        dmem_addr      <= aluout;
                        dmem_req       <= 1'b1;
                        wait_cnt_reg   <= '0;
                        is_store_reg   <= is_store_op;
                        store_data_reg <= M_Data;
                        if (Mem_Control_out) begin
                            dmem_we   <= 1'b0;
                            state_reg <= PTR;
                        end else begin
                            dmem_we   <= is_store_op;
                            dmem_din  <= M_Data;
                            state_reg <= ACC;
                        end
                    end
                end
                PTR: begin
                    if (dmem_ack) begin
                        // Pointer arrives: reissue immediately at the pointed-to address.
                        dmem_addr    <= dmem_dout;
                        dmem_we      <= is_store_reg;
                        dmem_din     <= store_data_reg;
                        wait_cnt_reg <= '0;
                        state_reg    <= ACC;
                    end else if (timeout_hit) begin
                        dmem_req     <= 1'b0;
                        dmem_we      <= 1'b0;
                        memout       <= '0;
                        mem_err      <= 1'b1;
                        mem_done     <= 1'b1;
                        wait_cnt_reg <= '0;
                        state_reg    <= DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_next;
                    end
                end
                ACC: begin
                    if (dmem_ack) begin
                        dmem_req     <= 1'b0;
                        dmem_we      <= 1'b0;
                        if (!is_store_reg) begin
                            memout <= dmem_dout;
                        end
                        mem_done     <= 1'b1;
                        wait_cnt_reg <= '0;
                        state_reg    <= DONE;
                    end else if (timeout_hit) begin
                        dmem_req     <= 1'b0;
                        dmem_we      <= 1'b0;
                        memout       <= '0;
                        mem_err      <= 1'b1;
                        mem_done     <= 1'b1;
                        wait_cnt_reg <= '0;
                        state_reg    <= DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_next;
                    end
                end
                DONE: begin
                    mem_done  <= 1'b0;
                    mem_err   <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_memaccess_fsm.sv
// Directed bench for lc3_memaccess_fsm: table of instructions with a scripted
// memory responder, plus hand-written timeout, reset and ignore sequences.
module tb_lc3_memaccess_fsm;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_valid_in;
    logic [15:0] IR_Exec;
    logic [15:0] aluout;
    logic [15:0] M_Data;
    logic        Mem_Control_out;
    logic        mem_busy;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_din;
    logic [15:0] dmem_dout;
    logic        dmem_ack;
    logic [15:0] memout;
    logic        mem_done;
    logic        mem_err;

    int n_checks = 0;
    int n_fail   = 0;

    lc3_memaccess_fsm #(.DATA_W(16), .TIMEOUT_CYCLES(16)) dut (
        .clock           (clock),
        .reset           (reset),
        .mem_valid_in    (mem_valid_in),
        .IR_Exec         (IR_Exec),
        .aluout          (aluout),
        .M_Data          (M_Data),
        .Mem_Control_out (Mem_Control_out),
        .mem_busy        (mem_busy),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_din        (dmem_din),
        .dmem_dout       (dmem_dout),
        .dmem_ack        (dmem_ack),
        .memout          (memout),
        .mem_done        (mem_done),
        .mem_err         (mem_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] alu;
        logic [15:0] mdata;
        logic        ind;
        logic [15:0] ptr;
        logic [15:0] dout;
        int          w0;
        int          w1;
        logic [15:0] exp_memout;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one instruction, then act as memory with the scripted wait counts.
    // Inputs are scrambled right after the accept edge to prove they were latched.
    task automatic run_vec(input int idx, input vec_t v);
        int          n_acc;
        int          wt;
        logic [15:0] ea;
        logic        ewe;
        logic [15:0] rd;
        logic        st;
        st    = v.ir[12];
        n_acc = v.ind ? 2 : 1;
        @(negedge clock);
        mem_valid_in    = 1'b1;
        IR_Exec         = v.ir;
        aluout          = v.alu;
        M_Data          = v.mdata;
        Mem_Control_out = v.ind;
        @(negedge clock);
        mem_valid_in    = 1'b0;
        IR_Exec         = 16'h0000;
        aluout          = 16'hFFFF;
        M_Data          = 16'hA5A5;
        Mem_Control_out = ~v.ind;
        for (int a = 0; a < n_acc; a++) begin
            wt  = (a == 0) ? v.w0 : v.w1;
            ea  = (a == 0) ? v.alu : v.ptr;
            ewe = (a == n_acc - 1) ? st : 1'b0;
            rd  = (n_acc == 2 && a == 0) ? v.ptr : v.dout;
            for (int w = 0; w <= wt; w++) begin
                check($sformatf("v%0d a%0d w%0d req", idx, a, w), 32'(dmem_req), 32'd1);
                check($sformatf("v%0d a%0d w%0d addr", idx, a, w), 32'(dmem_addr), 32'(ea));
                check($sformatf("v%0d a%0d w%0d we", idx, a, w), 32'(dmem_we), 32'(ewe));
                if (ewe)
                    check($sformatf("v%0d a%0d w%0d din", idx, a, w), 32'(dmem_din), 32'(v.mdata));
                check($sformatf("v%0d a%0d w%0d done", idx, a, w), 32'(mem_done), 32'd0);
                check($sformatf("v%0d a%0d w%0d busy", idx, a, w), 32'(mem_busy), 32'd1);
                dmem_ack  = (w == wt);
                dmem_dout = (w == wt) ? rd : 16'hDEAD;
                @(negedge clock);
            end
            dmem_ack  = 1'b0;
            dmem_dout = 16'hDEAD;
        end
        check($sformatf("v%0d done", idx), 32'(mem_done), 32'd1);
        check($sformatf("v%0d err", idx), 32'(mem_err), 32'd0);
        check($sformatf("v%0d memout", idx), 32'(memout), 32'(v.exp_memout));
        check($sformatf("v%0d req_low", idx), 32'(dmem_req), 32'd0);
        check($sformatf("v%0d busy_done", idx), 32'(mem_busy), 32'd1);
        $display("txn %0d: ir=%h alu=%h ind=%0d memout=%h done=%0d err=%0d",
                 idx, v.ir, v.alu, v.ind, memout, mem_done, mem_err);
        @(negedge clock);
        check($sformatf("v%0d done_pulse", idx), 32'(mem_done), 32'd0);
        check($sformatf("v%0d idle", idx), 32'(mem_busy), 32'd0);
    endtask

    initial begin
        // LD zero-wait, STR 3 waits, LDI zero-wait, STI with waits,
        // LDR acked on the 16th waiting cycle (no error), ST zero-wait.
        vecs[0] = '{16'h2A05, 16'h3000, 16'h0000, 1'b0, 16'h0000, 16'hBEEF, 0,  0, 16'hBEEF};
        vecs[1] = '{16'h7283, 16'h4010, 16'h1234, 1'b0, 16'h0000, 16'h0BAD, 3,  0, 16'hBEEF};
        vecs[2] = '{16'hA400, 16'h5000, 16'h0000, 1'b1, 16'h6000, 16'h00AA, 0,  0, 16'h00AA};
        vecs[3] = '{16'hB600, 16'h5100, 16'h7777, 1'b1, 16'h6100, 16'h0BAD, 1,  2, 16'h00AA};
        vecs[4] = '{16'h6123, 16'h0100, 16'h0000, 1'b0, 16'h0000, 16'h0F0F, 15, 0, 16'h0F0F};
        vecs[5] = '{16'h3000, 16'h2222, 16'h5555, 1'b0, 16'h0000, 16'h0BAD, 0,  0, 16'h0F0F};

        reset           = 1'b1;
        mem_valid_in    = 1'b0;
        IR_Exec         = 16'h0000;
        aluout          = 16'h0000;
        M_Data          = 16'h0000;
        Mem_Control_out = 1'b0;
        dmem_ack        = 1'b0;
        dmem_dout       = 16'h0000;
        repeat (2) @(negedge clock);
        check("rst busy", 32'(mem_busy), 32'd0);
        check("rst req", 32'(dmem_req), 32'd0);
        check("rst we", 32'(dmem_we), 32'd0);
        check("rst addr", 32'(dmem_addr), 32'd0);
        check("rst din", 32'(dmem_din), 32'd0);
        check("rst memout", 32'(memout), 32'd0);
        check("rst done", 32'(mem_done), 32'd0);
        check("rst err", 32'(mem_err), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Ack while no request is outstanding must be ignored.
        dmem_ack  = 1'b1;
        dmem_dout = 16'hFFFF;
        repeat (2) @(negedge clock);
        check("stray ack req", 32'(dmem_req), 32'd0);
        check("stray ack busy", 32'(mem_busy), 32'd0);
        check("stray ack memout", 32'(memout), 32'h0F0F);
        dmem_ack = 1'b0;
        $display("txn stray ack: memout=%h busy=%0d", memout, mem_busy);

        // Timeout: LD never acked for 16 cycles.
        mem_valid_in    = 1'b1;
        IR_Exec         = 16'h2000;
        aluout          = 16'h0777;
        Mem_Control_out = 1'b0;
        @(negedge clock);
        mem_valid_in = 1'b0;
        for (int c = 0; c < 16; c++) begin
            check($sformatf("to c%0d req", c), 32'(dmem_req), 32'd1);
            check($sformatf("to c%0d done", c), 32'(mem_done), 32'd0);
            @(negedge clock);
        end
        check("to done", 32'(mem_done), 32'd1);
        check("to err", 32'(mem_err), 32'd1);
        check("to memout", 32'(memout), 32'd0);
        check("to req", 32'(dmem_req), 32'd0);
        $display("txn timeout: done=%0d err=%0d memout=%h", mem_done, mem_err, memout);
        @(negedge clock);
        check("to err clear", 32'(mem_err), 32'd0);
        check("to idle", 32'(mem_busy), 32'd0);

        // Reset while an LDI sits in its pointer read.
        mem_valid_in    = 1'b1;
        IR_Exec         = 16'hA000;
        aluout          = 16'h5000;
        Mem_Control_out = 1'b1;
        @(negedge clock);
        mem_valid_in = 1'b0;
        check("rstmid req before", 32'(dmem_req), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rstmid req", 32'(dmem_req), 32'd0);
        check("rstmid busy", 32'(mem_busy), 32'd0);
        check("rstmid done", 32'(mem_done), 32'd0);
        dmem_ack  = 1'b1;
        dmem_dout = 16'h1111;
        @(negedge clock);
        dmem_ack = 1'b0;
        check("rstmid done later", 32'(mem_done), 32'd0);
        check("rstmid memout", 32'(memout), 32'd0);
        $display("txn reset mid-LDI: req=%0d busy=%0d done=%0d", dmem_req, mem_busy, mem_done);

        // ADD opcode with valid asserted is not a memory instruction.
        mem_valid_in    = 1'b1;
        IR_Exec         = 16'h1234;
        aluout          = 16'h3000;
        Mem_Control_out = 1'b0;
        repeat (2) begin
            @(negedge clock);
            check("add busy", 32'(mem_busy), 32'd0);
            check("add req", 32'(dmem_req), 32'd0);
        end
        mem_valid_in = 1'b0;
        $display("txn ADD ignored: busy=%0d req=%0d", mem_busy, dmem_req);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
